id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection and stall/bubble control.
- Sits between decode and execute.
- Its ex_rs_a, ex_rt_a and ex_rd_a outputs feed the EX forwarding unit and EX/MEM register.
- It covers the case forwarding cannot resolve: a consumer directly behind a load. It holds IF/ID and PC and inserts bubbles until the load data is forwardable.

Parameters:
- DATA_W, 32, datapath width.
- LOAD_BUBBLES, 1, bubbles per load-use hazard (1..3; raise for multi-cycle data memory).
- ALUOP_W, 4, ALU opcode width.

Ports:
- clk input 1 system clock.
- rst input 1 reset. Asynchronous and active-high; one clock domain only.
- id_valid input 1 decode slot holds a real instruction.
- id_rs_a input 5 rs address.
- id_rt_a input 5 rt address.
- id_rd_a input 5 destination address (already muxed rt/rd).
- id_uses_rt input 1 instruction reads rt as a source.
- id_rs_d input DATA_W rs register-file data.
- id_rt_d input DATA_W rt register-file data.
- id_imm input DATA_W sign-extended immediate.
- id_RegWrite input 1 control.
- id_MemRead input 1 control.
- id_MemWrite input 1 control.
- id_MemToReg input 1 control.
- id_AluSrc input 1 control.
- id_AluOp input ALUOP_W control.
- flush input 1 branch/jump taken in EX; kill the instruction in decode.
- stall output 1 hold PC and IF/ID this cycle.
- ex_valid output 1 EX slot valid.
- ex_rs_a, ex_rt_a, ex_rd_a output 5 each; registered addresses.
- ex_rs_d, ex_rt_d, ex_imm output DATA_W each; registered data.
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_AluSrc output 1 each; registered controls.
- ex_AluOp output ALUOP_W registered control.
- stall_count output 32 saturating count of stall cycles (performance).

Behaviour:
- Reset (async, on rst high) sets:
  - every ex_* output, stall_count and the bubble counter to 0;
  - the FSM to RUN.
  - stall reads 0 while rst is high.
- Hazard in RUN (combinational):
  - hz = id_valid && ex_valid && ex_MemRead && ex_rd_a!=0 && (ex_rd_a==id_rs_a || (id_uses_rt && ex_rd_a==id_rt_a)).
- Hazard in STALL:
  - Same compare against the latched load destination ld_rd instead of ex_rd_a.
  - The stall holds while the bubble counter is nonzero.
- stall = !flush && (hz in RUN || state==STALL). Purely combinational, same-cycle, no latency.
- FSM RUN:
  - If hz and !flush: capture ld_rd = ex_rd_a and load a bubble-counter of LOAD_BUBBLES-1.
  - Insert a bubble at the next edge (ex_valid and all ex_* controls to 0; data/address fields may be don't-care, but drive 0).
  - Go to STALL if LOAD_BUBBLES>1, else stay in RUN.
  - Otherwise capture all id_* into ex_* on each edge; ex_valid = id_valid.
- FSM STALL:
  - Each edge inserts a bubble and decrements the counter.
  - When it reaches 0, return to RUN. The held decode instruction is captured on the following edge.
- Flush has priority over stall in any state:
  - Next edge loads a bubble, FSM goes to RUN, counter clears, stall=0 that cycle.
- Bubble = ex_valid=0 with all ex_* controls 0. A bubble must never assert RegWrite, MemRead or MemWrite.
- Register $0:
  - A load to $0 never causes a stall.
  - An instruction with id_rs_a==0 matching a load to 0 must not stall.
- Instruction with id_valid=0: never stalls.
- Back-to-back loads: a load stalled behind a load is checked against the first load only. After the release edge, the second load is in EX and checked normally.
- stall_count increments by 1 on every edge where stall=1 and saturates at 0xFFFFFFFF.
- Latency: ID to EX is 1 cycle with no hazard; 1+LOAD_BUBBLES cycles on a load-use hazard.

Decomposition:
- Shared pipeline package holds:
  - REG_ADDR_W=5 and DATA_W;
  - the ALU opcode width;
  - a struct/bundle of EX control bits and its all-zero bubble constant.
- Package also holds the FSM state encoding: RUN=0, STALL=1.
- One natural sub-module: load_use_detect. A combinational compare producing hz from (id addresses, id_uses_rt, id_valid, candidate rd, candidate MemRead/valid). It is instantiated once, fed by a mux of ex_rd_a or ld_rd.

Test Plan:
- Reset mid-stall:
  - LOAD_BUBBLES=3; assert rst in the second STALL cycle.
  - Required: all ex_* are 0 and stall is 0 immediately; after release, normal capture resumes with stall_count=0.
- Plain flow: add with rs=1 rt=2 rd=3, id_valid=1.
  - Required: next cycle ex_rs_a=1, ex_rt_a=2, ex_rd_a=3, ex_valid=1, ex_RegWrite=1, stall=0 throughout.
- Load-use: lw to $5 in EX, then add with rs=5 in ID.
  - Required: stall=1 for exactly 1 cycle; the following edge gives ex_valid=0 and controls 0; the edge after gives the add in EX; stall_count=1.
- Load to $0 with a consumer of rs=0, and a load to $7 with a consumer whose rt=7 but id_uses_rt=0.
  - Required: stall=0 in both cases.
- LOAD_BUBBLES=2 load-use:
  - Required: stall high 2 cycles, two consecutive bubbles, then consumer in EX; stall_count=2.
- Flush during stall: hazard active and flush=1 in the same cycle.
  - Required: stall=0; next edge gives a bubble, FSM in RUN; the next valid id_* is captured normally.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline register: widths, EX control bundle
// and the load-use stall FSM encoding.
package id_ex_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int ALUOP_W    = 4;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use compare: does the decode instruction read the register a pending load writes?
module load_use_detect
  import id_ex_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_a,
  input  logic [REG_ADDR_W-1:0] id_rt_a,
  input  logic                  id_uses_rt,
  input  logic                  cand_valid,
  input  logic                  cand_mem_read,
  input  logic [REG_ADDR_W-1:0] cand_rd,
  output logic                  hz
);
  // $0 is hardwired, so a load targeting it can never feed a consumer.
  assign hz = id_valid && cand_valid && cand_mem_read && (cand_rd != '0) &&
              ((cand_rd == id_rs_a) || (id_uses_rt && (cand_rd == id_rt_a)));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion and flush.
module id_ex_stage #(
  parameter int DATA_W       = id_ex_pkg::DATA_W,
  parameter int LOAD_BUBBLES = 1,
  parameter int ALUOP_W      = id_ex_pkg::ALUOP_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [id_ex_pkg::REG_ADDR_W-1:0] id_rs_a,
  input  logic [id_ex_pkg::REG_ADDR_W-1:0] id_rt_a,
  input  logic [id_ex_pkg::REG_ADDR_W-1:0] id_rd_a,
  input  logic                            id_uses_rt,
  input  logic [DATA_W-1:0]               id_rs_d,
  input  logic [DATA_W-1:0]               id_rt_d,
  input  logic [DATA_W-1:0]               id_imm,
  input  logic                            id_RegWrite,
  input  logic                            id_MemRead,
  input  logic                            id_MemWrite,
  input  logic                            id_MemToReg,
  input  logic                            id_AluSrc,
  input  logic [ALUOP_W-1:0]              id_AluOp,
  input  logic                            flush,
  output logic                            stall,
  output logic                            ex_valid,
  output logic [id_ex_pkg::REG_ADDR_W-1:0] ex_rs_a,
  output logic [id_ex_pkg::REG_ADDR_W-1:0] ex_rt_a,
  output logic [id_ex_pkg::REG_ADDR_W-1:0] ex_rd_a,
  output logic [DATA_W-1:0]               ex_rs_d,
  output logic [DATA_W-1:0]               ex_rt_d,
  output logic [DATA_W-1:0]               ex_imm,
  output logic                            ex_RegWrite,
  output logic                            ex_MemRead,
  output logic                            ex_MemWrite,
  output logic                            ex_MemToReg,
  output logic                            ex_AluSrc,
  output logic [ALUOP_W-1:0]              ex_AluOp,
  output logic [31:0]                     stall_count
);
  import id_ex_pkg::*;

  state_t                state;
  logic [1:0]            bub_cnt;
  logic [REG_ADDR_W-1:0] ld_rd;
  ex_ctrl_t              ex_ctrl;
  logic                  hz;
  logic                  in_stall;
  logic                  bubble;

  assign in_stall = (state == STALL);

  // While stalled the load has left EX, so compare against its latched destination.
  load_use_detect u_detect (
    .id_valid      (id_valid),
    .id_rs_a       (id_rs_a),
    .id_rt_a       (id_rt_a),
    .id_uses_rt    (id_uses_rt),
    .cand_valid    (in_stall ? 1'b1 : ex_valid),
    .cand_mem_read (in_stall ? 1'b1 : ex_ctrl.mem_read),
    .cand_rd       (in_stall ? ld_rd : ex_rd_a),
    .hz            (hz)
  );

  assign stall  = !rst && !flush && (in_stall || hz);
  assign bubble = flush || stall;

  assign ex_RegWrite = ex_ctrl.reg_write;
  assign ex_MemRead  = ex_ctrl.mem_read;
  assign ex_MemWrite = ex_ctrl.mem_write;
  assign ex_MemToReg = ex_ctrl.mem_to_reg;
  assign ex_AluSrc   = ex_ctrl.alu_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      bub_cnt <= '0;
      ld_rd   <= '0;
    end else if (flush) begin
      state   <= RUN;
      bub_cnt <= '0;
    end else if (in_stall) begin
      bub_cnt <= bub_cnt - 2'd1;
      if (bub_cnt == 2'd1) state <= RUN;
    end else if (hz) begin
      ld_rd   <= ex_rd_a;
      bub_cnt <= 2'(LOAD_BUBBLES - 1);
      state   <= (LOAD_BUBBLES > 1) ? STALL : RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      ex_valid <= 1'b0;
      ex_rs_a  <= '0;
      ex_rt_a  <= '0;
      ex_rd_a  <= '0;
      ex_rs_d  <= '0;
      ex_rt_d  <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= CTRL_BUBBLE;
      ex_AluOp <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_rs_a  <= id_rs_a;
      ex_rt_a  <= id_rt_a;
      ex_rd_a  <= id_rd_a;
      ex_rs_d  <= id_rs_d;
      ex_rt_d  <= id_rt_d;
      ex_imm   <= id_imm;
      ex_ctrl  <= '{reg_write: id_RegWrite, mem_read: id_MemRead, mem_write: id_MemWrite,
                    mem_to_reg: id_MemToReg, alu_src: id_AluSrc};
      ex_AluOp <= id_AluOp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count <= '0;
    else if (stall && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: three instances (LOAD_BUBBLES 1..3) on shared stimulus.
module tb_id_ex_stage;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [31:0] rs_d, rt_d, imm;
    logic        rw, mr, mw, mtr, as;
    logic [3:0]  op;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm;
    logic        rw, mr, mw, mtr, as;
    logic [3:0]  op;
  } exo_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs, rt, rd;
    logic       uses_rt, rw, mr, flush;
    logic       e_stall, e_valid;
    logic [4:0] e_rs, e_rd;
    logic       e_rw, e_mr;
    logic [31:0] e_cnt;
  } row_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  in_t   stim = '0;
  logic  stall_o [3];
  exo_t  ex_o    [3];
  logic [31:0] cnt_o [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    logic v, rw, mr, mw, mtr, as;
    logic [4:0] rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm;
    logic [3:0] op;
    id_ex_stage #(.DATA_W(32), .LOAD_BUBBLES(k + 1), .ALUOP_W(4)) u_dut (
      .clk(clk), .rst(rst), .id_valid(stim.valid),
      .id_rs_a(stim.rs), .id_rt_a(stim.rt), .id_rd_a(stim.rd), .id_uses_rt(stim.uses_rt),
      .id_rs_d(stim.rs_d), .id_rt_d(stim.rt_d), .id_imm(stim.imm),
      .id_RegWrite(stim.rw), .id_MemRead(stim.mr), .id_MemWrite(stim.mw),
      .id_MemToReg(stim.mtr), .id_AluSrc(stim.as), .id_AluOp(stim.op), .flush(stim.flush),
      .stall(stall_o[k]), .ex_valid(v), .ex_rs_a(rs), .ex_rt_a(rt), .ex_rd_a(rd),
      .ex_rs_d(rs_d), .ex_rt_d(rt_d), .ex_imm(imm),
      .ex_RegWrite(rw), .ex_MemRead(mr), .ex_MemWrite(mw), .ex_MemToReg(mtr),
      .ex_AluSrc(as), .ex_AluOp(op), .stall_count(cnt_o[k])
    );
    assign ex_o[k] = '{valid: v, rs: rs, rt: rt, rd: rd, rs_d: rs_d, rt_d: rt_d, imm: imm,
                       rw: rw, mr: mr, mw: mw, mtr: mtr, as: as, op: op};
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: outstanding bubbles per instance plus the EX slot contents.
  exo_t        m_ex  [3];
  int          m_rem [3];
  logic [31:0] m_cnt [3];

  function automatic logic m_hz(input exo_t e);
    return stim.valid && e.valid && e.mr && e.rd != 0 &&
           (e.rd == stim.rs || (stim.uses_rt && e.rd == stim.rt));
  endfunction

  function automatic logic m_stall(input int k);
    return !stim.flush && (m_rem[k] > 0 || m_hz(m_ex[k]));
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_ex[k] = '0; m_rem[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic m_edge();
    for (int k = 0; k < 3; k++) begin
      if (m_stall(k) && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k]++;
      if (stim.flush) begin
        m_ex[k] = '0; m_rem[k] = 0;
      end else if (m_rem[k] > 0) begin
        m_ex[k] = '0; m_rem[k]--;
      end else if (m_hz(m_ex[k])) begin
        m_ex[k] = '0; m_rem[k] = k;
      end else begin
        m_ex[k] = '{valid: stim.valid, rs: stim.rs, rt: stim.rt, rd: stim.rd,
                    rs_d: stim.rs_d, rt_d: stim.rt_d, imm: stim.imm, rw: stim.rw,
                    mr: stim.mr, mw: stim.mw, mtr: stim.mtr, as: stim.as, op: stim.op};
      end
    end
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic ut, input logic rw,
                           input logic mr, input logic fl);
    stim = '0;
    stim.valid = v; stim.rs = rs; stim.rt = rt; stim.rd = rd; stim.uses_rt = ut;
    stim.rw = rw; stim.mr = mr; stim.flush = fl;
    stim.rs_d = 32'hA5A5_0000 | 32'(rs); stim.rt_d = 32'h5A5A_0000 | 32'(rt);
    stim.imm = 32'h0000_1234;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; stim = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  row_t rows [18];

  initial begin
    // valid rs rt rd ut rw mr fl | stall v rs rd rw mr cnt
    rows[0]  = '{1, 1, 2, 3, 1, 1, 0, 0,  0, 1, 1, 3, 1, 0, 0};
    rows[1]  = '{1, 1, 0, 5, 0, 1, 1, 0,  0, 1, 1, 5, 1, 1, 0};
    rows[2]  = '{1, 5, 2, 6, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 1};
    rows[3]  = '{1, 5, 2, 6, 1, 1, 0, 0,  0, 1, 5, 6, 1, 0, 1};
    rows[4]  = '{1, 1, 0, 0, 0, 1, 1, 0,  0, 1, 1, 0, 1, 1, 1};
    rows[5]  = '{1, 0, 0, 4, 1, 1, 0, 0,  0, 1, 0, 4, 1, 0, 1};
    rows[6]  = '{1, 1, 0, 7, 0, 1, 1, 0,  0, 1, 1, 7, 1, 1, 1};
    rows[7]  = '{1, 1, 7, 8, 0, 1, 0, 0,  0, 1, 1, 8, 1, 0, 1};
    rows[8]  = '{1, 1, 0, 7, 0, 1, 1, 0,  0, 1, 1, 7, 1, 1, 1};
    rows[9]  = '{0, 7, 7, 9, 1, 0, 0, 0,  0, 0, 7, 9, 0, 0, 1};
    rows[10] = '{1, 1, 0, 9, 0, 1, 1, 0,  0, 1, 1, 9, 1, 1, 1};
    rows[11] = '{1, 1, 9, 10, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    rows[12] = '{1, 9, 9, 11, 1, 1, 0, 0, 0, 1, 9, 11, 1, 0, 1};
    rows[13] = '{1, 1, 0, 12, 0, 1, 1, 0, 0, 1, 1, 12, 1, 1, 1};
    rows[14] = '{1, 12, 0, 13, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2};
    rows[15] = '{1, 12, 0, 13, 0, 1, 1, 0, 0, 1, 12, 13, 1, 1, 2};
    rows[16] = '{1, 13, 0, 14, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3};
    rows[17] = '{1, 13, 0, 14, 0, 1, 0, 0, 0, 1, 13, 14, 1, 0, 3};

    // Reset state
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ex", 128'(ex_o[k]), 128'(0));
      chk("reset_stall", 128'(stall_o[k]), 128'(0));
      chk("reset_cnt", 128'(cnt_o[k]), 128'(0));
    end
    @(negedge clk); rst = 1'b0;

    // Directed table against the single-bubble instance
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      set_instr(rows[i].valid, rows[i].rs, rows[i].rt, rows[i].rd, rows[i].uses_rt,
                rows[i].rw, rows[i].mr, rows[i].flush);
      #1 chk($sformatf("row%0d_stall", i), 128'(stall_o[0]), 128'(rows[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("row%0d_ex", i),
          128'({ex_o[0].valid, ex_o[0].rs, ex_o[0].rd, ex_o[0].rw, ex_o[0].mr}),
          128'({rows[i].e_valid, rows[i].e_rs, rows[i].e_rd, rows[i].e_rw, rows[i].e_mr}));
      chk($sformatf("row%0d_cnt", i), 128'(cnt_o[0]), 128'(rows[i].e_cnt));
    end

    // Two-bubble load-use
    pulse_reset();
    set_instr(1, 1, 0, 5, 0, 1, 1, 0);
    @(posedge clk); @(negedge clk);
    set_instr(1, 5, 2, 6, 1, 1, 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1 chk($sformatf("lb2_stall%0d", c), 128'(stall_o[1]), 128'(1));
      @(posedge clk); #1;
      chk($sformatf("lb2_bubble%0d", c),
          128'({ex_o[1].valid, ex_o[1].rw, ex_o[1].mr, ex_o[1].mw}), 128'(0));
      @(negedge clk);
    end
    #1 chk("lb2_release", 128'(stall_o[1]), 128'(0));
    @(posedge clk); #1;
    chk("lb2_consumer", 128'({ex_o[1].valid, ex_o[1].rs, ex_o[1].rd}), 128'({1'b1, 5'd5, 5'd6}));
    chk("lb2_cnt", 128'(cnt_o[1]), 128'(2));

    // Reset in the second STALL cycle of the three-bubble instance
    pulse_reset();
    set_instr(1, 1, 0, 5, 0, 1, 1, 0);
    @(posedge clk); @(negedge clk);
    set_instr(1, 5, 2, 6, 1, 1, 0, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1 chk("lb3_stalling", 128'(stall_o[2]), 128'(1));
    rst = 1'b1;
    #1;
    chk("lb3_rst_ex", 128'(ex_o[2]), 128'(0));
    chk("lb3_rst_stall", 128'(stall_o[2]), 128'(0));
    @(negedge clk); rst = 1'b0;
    set_instr(1, 1, 2, 3, 1, 1, 0, 0);
    @(posedge clk); #1;
    chk("lb3_resume", 128'({ex_o[2].valid, ex_o[2].rs, ex_o[2].rt, ex_o[2].rd, ex_o[2].rw}),
        128'({1'b1, 5'd1, 5'd2, 5'd3, 1'b1}));
    chk("lb3_cnt", 128'(cnt_o[2]), 128'(0));

    // Randomized run against the reference model
    pulse_reset();
    m_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      stim.valid   = ($urandom % 8) != 0;
      stim.rs      = 5'($urandom % 4);
      stim.rt      = 5'($urandom % 4);
      stim.rd      = 5'($urandom % 4);
      stim.uses_rt = 1'($urandom);
      stim.rs_d    = $urandom;
      stim.rt_d    = $urandom;
      stim.imm     = $urandom;
      stim.rw      = 1'($urandom);
      stim.mr      = 1'($urandom);
      stim.mw      = 1'($urandom);
      stim.mtr     = 1'($urandom);
      stim.as      = 1'($urandom);
      stim.op      = 4'($urandom);
      stim.flush   = ($urandom % 10) == 0;
      #1;
      for (int k = 0; k < 3; k++)
        chk($sformatf("rnd_stall_lb%0d", k + 1), 128'(stall_o[k]), 128'(m_stall(k)));
      @(posedge clk);
      m_edge();
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd_ex_lb%0d", k + 1), 128'(ex_o[k]), 128'(m_ex[k]));
        chk($sformatf("rnd_cnt_lb%0d", k + 1), 128'(cnt_o[k]), 128'(m_cnt[k]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
